// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared encodings for the hazard/forwarding controller and the forwarding
//   muxes that consume its select codes.
//   Contents:
//     MF_*      3-bit forward-select codes driven to the D/E/M forwarding muxes
//     KIND_*    result-source class of a producing instruction
//     TUSE_NONE tuse value meaning "operand never read"
//     MD_*      multiply/divide unit instruction class
//     tnewAtE   result age of an instruction as it enters E
//     tnewStep  one-stage ageing of a result age, saturating at zero
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam logic [2:0] MF_RD   = 3'd0;
    localparam logic [2:0] MF_PC4E = 3'd1;
    localparam logic [2:0] MF_AO   = 3'd2;
    localparam logic [2:0] MF_PC4M = 3'd3;
    localparam logic [2:0] MF_WD   = 3'd4;

    localparam logic [1:0] KIND_ALU  = 2'd0;
    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [1:0] KIND_LINK = 2'd2;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] MD_NONE = 2'd0;
    localparam logic [1:0] MD_MULT = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;
    localparam logic [1:0] MD_HILO = 2'd3;

    // Unlisted kind encodings are treated like ALU results.
    function automatic logic [1:0] tnewAtE(input logic [1:0] kind);
        logic [1:0] t;
        case (kind)
            KIND_LOAD: t = 2'd2;
            KIND_LINK: t = 2'd0;
            default:   t = 2'd1;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] tnewStep(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_pick.sv
// ---------------------------------------------------------------------------
// fwd_pick
//   Forward-source selection for one consumer register. Finds the youngest
//   in-flight producer of r_i among the enabled stages (E > M > W) and turns
//   its result age into a forwarding select code.
//   Ports:
//     r_i          consumer register index (0 never forwards)
//     useE_i       consider the E-stage producer
//     useM_i       consider the M-stage producer
//     eA3_i/eTnew_i            E-stage destination and result age
//     mA3_i/mTnew_i/mKind_i    M-stage destination, result age, result kind
//     wA3_i        W-stage destination (W results are always ready)
//     sel_o        MF_* select code (MF_RD when no match or not ready)
//     notReady_o   winning producer exists but its result is not yet ready
//     tnew_o       result age of the winning producer (0 when none)
// ---------------------------------------------------------------------------
module fwd_pick
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] r_i,
    input  logic       useE_i,
    input  logic       useM_i,
    input  logic [4:0] eA3_i,
    input  logic [1:0] eTnew_i,
    input  logic [4:0] mA3_i,
    input  logic [1:0] mTnew_i,
    input  logic [1:0] mKind_i,
    input  logic [4:0] wA3_i,
    output logic [2:0] sel_o,
    output logic       notReady_o,
    output logic [1:0] tnew_o
);

    logic hitE;
    logic hitM;
    logic hitW;

    assign hitE = useE_i && (r_i != 5'd0) && (eA3_i == r_i);
    assign hitM = useM_i && (r_i != 5'd0) && (mA3_i == r_i);
    assign hitW = (r_i != 5'd0) && (wA3_i == r_i);

    // Only the youngest match matters; an older writer of the same register
    // holds a stale value. In E the only ready result is a link address.
    always_comb begin
        sel_o      = MF_RD;
        notReady_o = 1'b0;
        tnew_o     = 2'd0;
        if (hitE) begin
            tnew_o = eTnew_i;
            if (eTnew_i == 2'd0) begin
                sel_o = MF_PC4E;
            end else begin
                notReady_o = 1'b1;
            end
        end else if (hitM) begin
            tnew_o = mTnew_i;
            if (mTnew_i == 2'd0) begin
                sel_o = (mKind_i == KIND_LINK) ? MF_PC4M : MF_AO;
            end else begin
                notReady_o = 1'b1;
            end
        end else if (hitW) begin
            sel_o = MF_WD;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Producer-side hazard unit for the 5-stage pipeline. Keeps a shadow copy
//   of destination, result age (tnew) and result kind for the instructions
//   in E, M and W, plus the consumer indices of E (rs, rt) and M (rt), and
//   derives the forwarding selects and the D-stage stall from them.
//   Optional feature macro: HAZARD_MDU_EN adds a multiply/divide busy
//   counter that stalls HI/LO users in D while the unit is busy.
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     rs_d, rt_d                   D-stage source register indices
//     tuse_rs_d, tuse_rt_d         cycles until each source is needed (3 = never)
//     a3_d                         D-stage destination (0 = none)
//     kind_d                       D-stage result kind (ALU / LOAD / LINK)
//     md_d                         D-stage MDU class (used with HAZARD_MDU_EN)
//     stall                        freeze PC and IF/D, bubble into E
//     fsel_rs_d, fsel_rt_d         forward selects for D operands
//     fsel_rs_e, fsel_rt_e         forward selects for E operands
//     fsel_rt_m                    forward select for M store data
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] a3_d,
    input  logic [1:0] kind_d,
    input  logic [1:0] md_d,
    output logic       stall,
    output logic [2:0] fsel_rs_d,
    output logic [2:0] fsel_rt_d,
    output logic [2:0] fsel_rs_e,
    output logic [2:0] fsel_rt_e,
    output logic [2:0] fsel_rt_m
);

    logic [4:0] eA3_q, eA3_d;
    logic [1:0] eTnew_q, eTnew_d;
    logic [1:0] eKind_q, eKind_d;
    logic [4:0] eRs_q, eRs_d;
    logic [4:0] eRt_q, eRt_d;
    logic [4:0] mA3_q, mA3_d;
    logic [1:0] mTnew_q, mTnew_d;
    logic [1:0] mKind_q, mKind_d;
    logic [4:0] mRt_q, mRt_d;
    logic [4:0] wA3_q, wA3_d;

    logic       rsNotReady, rtNotReady;
    logic [1:0] rsTnew, rtTnew;
    logic       regStall;
    logic       mdStall;

    logic       rsENotReady, rtENotReady, rtMNotReady;
    logic [1:0] rsETnew, rtETnew, rtMTnew;
    logic       unusedSink;

    // D-stage consumers look at every in-flight stage.
    fwd_pick u_pick_rs_d (
        .r_i(rs_d), .useE_i(1'b1), .useM_i(1'b1),
        .eA3_i(eA3_q), .eTnew_i(eTnew_q),
        .mA3_i(mA3_q), .mTnew_i(mTnew_q), .mKind_i(mKind_q),
        .wA3_i(wA3_q),
        .sel_o(fsel_rs_d), .notReady_o(rsNotReady), .tnew_o(rsTnew)
    );

    fwd_pick u_pick_rt_d (
        .r_i(rt_d), .useE_i(1'b1), .useM_i(1'b1),
        .eA3_i(eA3_q), .eTnew_i(eTnew_q),
        .mA3_i(mA3_q), .mTnew_i(mTnew_q), .mKind_i(mKind_q),
        .wA3_i(wA3_q),
        .sel_o(fsel_rt_d), .notReady_o(rtNotReady), .tnew_o(rtTnew)
    );

    // E-stage consumers can only be fed by older instructions in M and W.
    fwd_pick u_pick_rs_e (
        .r_i(eRs_q), .useE_i(1'b0), .useM_i(1'b1),
        .eA3_i(eA3_q), .eTnew_i(eTnew_q),
        .mA3_i(mA3_q), .mTnew_i(mTnew_q), .mKind_i(mKind_q),
        .wA3_i(wA3_q),
        .sel_o(fsel_rs_e), .notReady_o(rsENotReady), .tnew_o(rsETnew)
    );

    fwd_pick u_pick_rt_e (
        .r_i(eRt_q), .useE_i(1'b0), .useM_i(1'b1),
        .eA3_i(eA3_q), .eTnew_i(eTnew_q),
        .mA3_i(mA3_q), .mTnew_i(mTnew_q), .mKind_i(mKind_q),
        .wA3_i(wA3_q),
        .sel_o(fsel_rt_e), .notReady_o(rtENotReady), .tnew_o(rtETnew)
    );

    // Store data in M can only come from W.
    fwd_pick u_pick_rt_m (
        .r_i(mRt_q), .useE_i(1'b0), .useM_i(1'b0),
        .eA3_i(eA3_q), .eTnew_i(eTnew_q),
        .mA3_i(mA3_q), .mTnew_i(mTnew_q), .mKind_i(mKind_q),
        .wA3_i(wA3_q),
        .sel_o(fsel_rt_m), .notReady_o(rtMNotReady), .tnew_o(rtMTnew)
    );

    // A D operand stalls when its producer needs more cycles than the
    // consumer can wait. tuse of 3 can never be exceeded (tnew <= 2).
    assign regStall = (rsNotReady && (rsTnew > tuse_rs_d)) ||
                      (rtNotReady && (rtTnew > tuse_rt_d));

    assign stall = regStall | mdStall;

`ifdef HAZARD_MDU_EN
    logic [1:0] eMd_q, eMd_d;
    logic [3:0] mduCnt_q, mduCnt_d;
    logic       eMdStart;

    assign eMdStart = (eMd_q == MD_MULT) || (eMd_q == MD_DIV);

    // The counter is loaded once the start instruction sits in E, so the
    // start cycle itself is covered by eMdStart rather than the counter.
    assign mdStall = (md_d != MD_NONE) && ((mduCnt_q != 4'd0) || eMdStart);

    // Bubbles carry MD_NONE, so a stalled start never reloads the counter.
    always_comb begin
        eMd_d    = stall ? MD_NONE : md_d;
        mduCnt_d = mduCnt_q;
        if (eMdStart) begin
            mduCnt_d = (eMd_q == MD_MULT) ? 4'(MULT_CYC) : 4'(DIV_CYC);
        end else if (mduCnt_q != 4'd0) begin
            mduCnt_d = mduCnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eMd_q    <= MD_NONE;
            mduCnt_q <= 4'd0;
        end else begin
            eMd_q    <= eMd_d;
            mduCnt_q <= mduCnt_d;
        end
    end

    assign unusedSink = ^{rsENotReady, rtENotReady, rtMNotReady,
                          rsETnew, rtETnew, rtMTnew};
`else
    // Without the MDU the md class and cycle counts have no effect.
    assign mdStall    = 1'b0;
    assign unusedSink = ^{rsENotReady, rtENotReady, rtMNotReady,
                          rsETnew, rtETnew, rtMTnew,
                          md_d, 4'(MULT_CYC), 4'(DIV_CYC)};
`endif

    // Shadow pipeline advance: a stall drops a bubble into E while M and W
    // keep moving. W results are always ready, so W keeps no age.
    always_comb begin
        eA3_d   = stall ? 5'd0 : a3_d;
        eTnew_d = stall ? 2'd0 : tnewAtE(kind_d);
        eKind_d = stall ? KIND_ALU : kind_d;
        eRs_d   = stall ? 5'd0 : rs_d;
        eRt_d   = stall ? 5'd0 : rt_d;
        mA3_d   = eA3_q;
        mTnew_d = tnewStep(eTnew_q);
        mKind_d = eKind_q;
        mRt_d   = eRt_q;
        wA3_d   = mA3_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eA3_q   <= 5'd0;
            eTnew_q <= 2'd0;
            eKind_q <= KIND_ALU;
            eRs_q   <= 5'd0;
            eRt_q   <= 5'd0;
            mA3_q   <= 5'd0;
            mTnew_q <= 2'd0;
            mKind_q <= KIND_ALU;
            mRt_q   <= 5'd0;
            wA3_q   <= 5'd0;
        end else begin
            eA3_q   <= eA3_d;
            eTnew_q <= eTnew_d;
            eKind_q <= eKind_d;
            eRs_q   <= eRs_d;
            eRt_q   <= eRt_d;
            mA3_q   <= mA3_d;
            mTnew_q <= mTnew_d;
            mKind_q <= mKind_d;
            mRt_q   <= mRt_d;
            wA3_q   <= wA3_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. A behavioural model tracks in-flight
//   instructions by their age in the pipeline and derives expected selects
//   and stall from those ages; it is compared with the DUT every cycle.
//   Directed literal expectations pin the model on the classic hazards.
//   Honours HAZARD_MDU_EN for the multiply/divide busy scenario.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    typedef struct packed {
        logic [4:0] a3;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] kind;
        logic [1:0] md;
    } instrT;

    typedef struct packed {
        logic       stall;
        logic [2:0] rsD;
        logic [2:0] rtD;
        logic [2:0] rsE;
        logic [2:0] rtE;
        logic [2:0] rtM;
    } expT;

    logic       clk;
    logic       rst_n;
    logic [4:0] rsD, rtD, a3D;
    logic [1:0] tuseRs, tuseRt, kindD, mdD;
    logic       stall;
    logic [2:0] fselRsD, fselRtD, fselRsE, fselRtE, fselRtM;

    int passCount;
    int checkCount;
    int cycleNum;
    int mdBusyUntil;

    // Index 0 = E, 1 = M, 2 = W; the index is also the instruction's age.
    instrT stg [3];

    hazard_ctrl #(.MULT_CYC(MULT_LAT), .DIV_CYC(DIV_LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rs_d(rsD),
        .rt_d(rtD),
        .tuse_rs_d(tuseRs),
        .tuse_rt_d(tuseRt),
        .a3_d(a3D),
        .kind_d(kindD),
        .md_d(mdD),
        .stall(stall),
        .fsel_rs_d(fselRsD),
        .fsel_rt_d(fselRtD),
        .fsel_rs_e(fselRsE),
        .fsel_rt_e(fselRtE),
        .fsel_rt_m(fselRtM)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycles still needed before a result exists, given age since entering E.
    function automatic int cyclesLeft(input logic [1:0] kind, input int age);
        int produceAge;
        produceAge = (kind == 2'd1) ? 2 : (kind == 2'd2) ? 0 : 1;
        return (produceAge > age) ? produceAge - age : 0;
    endfunction

    // Scan stages from youngest allowed to oldest; first writer of r decides.
    function automatic void pick(input logic [4:0] r, input int first,
                                 output logic [2:0] sel, output int left);
        bit found;
        sel   = 3'd0;
        left  = 0;
        found = 0;
        for (int s = first; s < 3; s++) begin
            if (!found && r != 5'd0 && stg[s].a3 == r) begin
                found = 1;
                left  = cyclesLeft(stg[s].kind, s);
                if (s == 2) sel = 3'd4;
                else if (left != 0) sel = 3'd0;
                else if (s == 0) sel = 3'd1;
                else sel = (stg[s].kind == 2'd2) ? 3'd3 : 3'd2;
            end
        end
    endfunction

    function automatic expT model();
        expT x;
        int lRs, lRt, ign;
        pick(rsD, 0, x.rsD, lRs);
        pick(rtD, 0, x.rtD, lRt);
        pick(stg[0].rs, 1, x.rsE, ign);
        pick(stg[0].rt, 1, x.rtE, ign);
        pick(stg[1].rt, 2, x.rtM, ign);
        x.stall = (lRs > int'(tuseRs)) || (lRt > int'(tuseRt));
`ifdef HAZARD_MDU_EN
        if (mdD != 2'd0 && cycleNum <= mdBusyUntil) x.stall = 1'b1;
`endif
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t",
                      name, actual, expected, $time);
    endtask

    // Model pipeline advance, mirroring what the real pipeline registers do.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg[0]      <= '0;
            stg[1]      <= '0;
            stg[2]      <= '0;
            cycleNum    <= 0;
            mdBusyUntil <= -1;
        end else begin
            stg[0]   <= model().stall ? '0 : {a3D, rsD, rtD, kindD, mdD};
            stg[1]   <= stg[0];
            stg[2]   <= stg[1];
            cycleNum <= cycleNum + 1;
            if (!model().stall && (mdD == 2'd1 || mdD == 2'd2))
                mdBusyUntil <= cycleNum + 1 + ((mdD == 2'd1) ? MULT_LAT : DIV_LAT);
        end
    end

    // Every cycle out of reset, compare all outputs with the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model_stall", {7'd0, stall}, {7'd0, model().stall});
            checkOutput("model_fsel_rs_d", {5'd0, fselRsD}, {5'd0, model().rsD});
            checkOutput("model_fsel_rt_d", {5'd0, fselRtD}, {5'd0, model().rtD});
            checkOutput("model_fsel_rs_e", {5'd0, fselRsE}, {5'd0, model().rsE});
            checkOutput("model_fsel_rt_e", {5'd0, fselRtE}, {5'd0, model().rtE});
            checkOutput("model_fsel_rt_m", {5'd0, fselRtM}, {5'd0, model().rtM});
        end
    end

    // Present one D-stage instruction just after a rising edge, then let the
    // combinational outputs settle before the caller looks at them.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [1:0] tRs, input logic [1:0] tRt,
                                 input logic [4:0] a3, input logic [1:0] kind,
                                 input logic [1:0] md);
        @(posedge clk);
        #1;
        rsD    = rs;
        rtD    = rt;
        tuseRs = tRs;
        tuseRt = tRt;
        a3D    = a3;
        kindD  = kind;
        mdD    = md;
        #2;
    endtask

    task automatic nop();
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stall"}, {7'd0, stall}, 8'd0);
        checkOutput({tag, "_rs_d"}, {5'd0, fselRsD}, 8'd0);
        checkOutput({tag, "_rt_d"}, {5'd0, fselRtD}, 8'd0);
        checkOutput({tag, "_rs_e"}, {5'd0, fselRsE}, 8'd0);
        checkOutput({tag, "_rt_e"}, {5'd0, fselRtE}, 8'd0);
        checkOutput({tag, "_rt_m"}, {5'd0, fselRtM}, 8'd0);
    endtask

    initial begin
        int n;
        bit done;
        passCount  = 0;
        checkCount = 0;
        rsD = 0; rtD = 0; a3D = 0; kindD = 0; mdD = 0;
        tuseRs = 2'd3; tuseRt = 2'd3;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ALU producer in E, branch needs it in D: one stall, then ALU out of M.
        applyStimulus(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd0, 2'd0);
        applyStimulus(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0);
        checkOutput("alu_beq_stall", {7'd0, stall}, 8'd1);
        applyStimulus(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0);
        checkOutput("alu_beq_release", {7'd0, stall}, 8'd0);
        checkOutput("alu_beq_fwd", {5'd0, fselRsD}, 8'd2);
        nop();

        // $4 written twice; the younger (M) copy must win over W.
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0, 2'd0);
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0, 2'd0);
        applyStimulus(5'd4, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 2'd0);
        checkOutput("dup_no_stall", {7'd0, stall}, 8'd0);
        nop();
        checkOutput("dup_youngest", {5'd0, fselRsE}, 8'd2);

        // Load-use with E consumer: one stall, later forwarded from W.
        applyStimulus(5'd0, 5'd0, 2'd1, 2'd3, 5'd5, 2'd1, 2'd0);
        applyStimulus(5'd0, 5'd5, 2'd3, 2'd1, 5'd6, 2'd0, 2'd0);
        checkOutput("lw_use_stall", {7'd0, stall}, 8'd1);
        applyStimulus(5'd0, 5'd5, 2'd3, 2'd1, 5'd6, 2'd0, 2'd0);
        checkOutput("lw_use_release", {7'd0, stall}, 8'd0);
        nop();
        checkOutput("lw_use_wd", {5'd0, fselRtE}, 8'd4);

        // jal then jr $31: link address forwarded from E, then from M.
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd2, 2'd0);
        applyStimulus(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
        checkOutput("jal_jr_stall", {7'd0, stall}, 8'd0);
        checkOutput("jal_jr_pc4e", {5'd0, fselRsD}, 8'd1);
        nop();
        checkOutput("jal_jr_pc4m", {5'd0, fselRsE}, 8'd3);

        // Writers and readers of $0 never forward or stall.
        applyStimulus(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd1, 2'd0);
        applyStimulus(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd1, 2'd0);
        applyStimulus(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd1, 2'd0);
        checkAllZero("zero_reg");

        // Store data in M forwarded from the ALU result now in W.
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd0, 2'd0);
        applyStimulus(5'd0, 5'd7, 2'd3, 2'd2, 5'd0, 2'd0, 2'd0);
        checkOutput("sw_no_stall", {7'd0, stall}, 8'd0);
        nop();
        checkOutput("sw_rt_e", {5'd0, fselRtE}, 8'd2);
        nop();
        checkOutput("sw_rt_m", {5'd0, fselRtM}, 8'd4);

        // Load followed by a D-stage branch: two stalls, then from W.
        applyStimulus(5'd0, 5'd0, 2'd1, 2'd3, 5'd8, 2'd1, 2'd0);
        applyStimulus(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
        checkOutput("lw_beq_stall1", {7'd0, stall}, 8'd1);
        applyStimulus(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
        checkOutput("lw_beq_stall2", {7'd0, stall}, 8'd1);
        applyStimulus(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
        checkOutput("lw_beq_release", {7'd0, stall}, 8'd0);
        checkOutput("lw_beq_wd", {5'd0, fselRsD}, 8'd4);

        // Asynchronous reset in the middle of a load-use stall.
        applyStimulus(5'd0, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 2'd0);
        applyStimulus(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
        checkOutput("midrst_pre", {7'd0, stall}, 8'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_stall", {7'd0, stall}, 8'd0);
        checkOutput("midrst_rs_d", {5'd0, fselRsD}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nop();

`ifdef HAZARD_MDU_EN
        // mult in E with mfhi waiting in D: six stall cycles in total.
        applyStimulus(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 2'd1);
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd0, 2'd3);
        n = 0;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            if (!done) begin
                if (stall) begin
                    n++;
                    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd0, 2'd3);
                end else begin
                    done = 1;
                end
            end
        end
        checkOutput("mdu_stall_len", 8'(n), 8'd6);
        nop();

        // Reset while the busy counter is running releases the stall at once.
        applyStimulus(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 2'd1);
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd0, 2'd3);
        applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd0, 2'd3);
        checkOutput("mdu_busy", {7'd0, stall}, 8'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mdu_rst_stall", {7'd0, stall}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nop();
`endif

        nop();
        nop();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
